// File: rtl/sram_responder_if.sv
// Active-low SRAM control bus between the LC-3 MAR/MDR path and the memory responder.
interface sram_responder_if;
  logic [19:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic        Mem_CE;
  logic        Mem_OE;
  logic        Mem_WE;
  logic        Mem_UB;
  logic        Mem_LB;
  logic [15:0] Data_to_CPU;
  logic        Data_valid;
  logic        Busy;

  modport master (
    output ADDR, Data_from_CPU, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB,
    input  Data_to_CPU, Data_valid, Busy
  );

  modport slave (
    input  ADDR, Data_from_CPU, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB,
    output Data_to_CPU, Data_valid, Busy
  );
endinterface

// File: rtl/sram_responder.sv
// On-chip stand-in for the LC-3 external SRAM: byte-masked writes, reads with READ_LATENCY edges.
// Optional MMIO at 20'hFFFF (Switches in, Hex_out out) enabled by defining SRAM_RESPONDER_MMIO_EN.
module sram_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  sram_responder_if.slave     bus,
  input  logic [15:0]         Switches,
  output logic [15:0]         Hex_out
);
  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [1:0] CNT_LOAD = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    READ_HOLD = 2'd2,
    WRITE     = 2'd3
  } state_t;

  state_t                r_state, w_next;
  logic [15:0]           r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_cnt, w_cnt_next;
  logic                  r_mmio;
  logic [15:0]           r_data;
  logic                  r_valid, r_busy;

  logic                  w_wr_req, w_rd_req, w_rd_stay, w_wr_stay, w_hit_mmio;
  logic                  w_commit, w_capture, w_load_data, w_ram_we, w_rd_mmio;
  logic [ADDR_WIDTH-1:0] w_idx, w_rd_addr;
  logic [15:0]           w_lane_mask, w_rd_word, w_mmio_word;

  assign w_idx       = bus.ADDR[ADDR_WIDTH-1:0];
  assign w_wr_req    = ~bus.Mem_CE & ~bus.Mem_WE;
  assign w_rd_req    = ~bus.Mem_CE & ~bus.Mem_OE & bus.Mem_WE;
  assign w_rd_stay   = ~bus.Mem_CE & ~bus.Mem_OE;
  assign w_wr_stay   = ~bus.Mem_CE & ~bus.Mem_WE;
  assign w_lane_mask = {{8{~bus.Mem_UB}}, {8{~bus.Mem_LB}}};

`ifdef SRAM_RESPONDER_MMIO_EN
  logic [15:0] r_hex;

  assign w_hit_mmio  = (bus.ADDR == 20'hFFFF);
  assign w_mmio_word = Switches;
  assign Hex_out     = r_hex;

  // MMIO output register takes the enabled bytes of a write to the MMIO address
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hex <= 16'h0000;
    end else if (w_commit && w_hit_mmio) begin
      if (!bus.Mem_UB) r_hex[15:8] <= bus.Data_from_CPU[15:8];
      if (!bus.Mem_LB) r_hex[7:0]  <= bus.Data_from_CPU[7:0];
    end
  end
`else
  logic w_unused_bits;

  assign w_hit_mmio    = 1'b0;
  assign w_mmio_word   = 16'h0000;
  assign Hex_out       = 16'h0000;
  assign w_unused_bits = ^{Switches, bus.ADDR[19:ADDR_WIDTH]};
`endif

  // The capture edge reads the live address; later edges use the captured one
  assign w_rd_addr = w_capture ? w_idx : r_addr;
  assign w_rd_mmio = w_capture ? w_hit_mmio : r_mmio;
  assign w_rd_word = w_rd_mmio ? w_mmio_word : r_mem[w_rd_addr];
  assign w_ram_we  = w_commit & ~w_hit_mmio;

  // Next-state and control decode
  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_commit    = 1'b0;
    w_capture   = 1'b0;
    w_load_data = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_wr_req) begin
          w_commit = 1'b1;
          w_next   = WRITE;
        end else if (w_rd_req) begin
          w_capture  = 1'b1;
          w_cnt_next = CNT_LOAD;
          if (CNT_LOAD == 2'd0) begin
            w_load_data = 1'b1;
            w_next      = READ_HOLD;
          end else begin
            w_next = READ_WAIT;
          end
        end else begin
          w_next = IDLE;
        end
      end
      READ_WAIT: begin
        if (!w_rd_stay) begin
          w_next = IDLE;
        end else if (r_cnt == 2'd1) begin
          w_cnt_next  = 2'd0;
          w_load_data = 1'b1;
          w_next      = READ_HOLD;
        end else begin
          w_cnt_next = r_cnt - 2'd1;
        end
      end
      READ_HOLD: begin
        if (!w_rd_stay) begin
          w_next = IDLE;
        end else begin
          w_load_data = 1'b1;
        end
      end
      WRITE: begin
        // Only the entry edge commits, so a long WE pulse writes once
        if (w_wr_stay) begin
          w_next = WRITE;
        end else begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State, latency counter and registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_addr  <= {ADDR_WIDTH{1'b0}};
      r_mmio  <= 1'b0;
      r_data  <= 16'h0000;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_valid <= (w_next == READ_HOLD);
      r_busy  <= (w_next != IDLE);
      if (w_capture) begin
        r_addr <= w_idx;
        r_mmio <= w_hit_mmio;
      end
      if (w_load_data) begin
        r_data <= w_rd_word & w_lane_mask;
      end
    end
  end

  // RAM write port; contents are kept across reset
  always_ff @(posedge Clk) begin
    if (w_ram_we) begin
      if (!bus.Mem_UB) r_mem[w_idx][15:8] <= bus.Data_from_CPU[15:8];
      if (!bus.Mem_LB) r_mem[w_idx][7:0]  <= bus.Data_from_CPU[7:0];
    end
  end

  assign bus.Data_to_CPU = r_data;
  assign bus.Data_valid  = r_valid;
  assign bus.Busy        = r_busy;
endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: latency-1 and latency-3 instances, table vectors,
// corner-case sequences and randomized traffic against a word-array reference model.
module tb_sram_responder;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Switches;
  logic [15:0] hex1, hex3;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 Clk = ~Clk;

  sram_responder_if b1();
  sram_responder_if b3();

  sram_responder #(.ADDR_WIDTH(10), .READ_LATENCY(1)) dut (
    .Clk(Clk), .Reset(Reset), .bus(b1), .Switches(Switches), .Hex_out(hex1));
  sram_responder #(.ADDR_WIDTH(10), .READ_LATENCY(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .bus(b3), .Switches(Switches), .Hex_out(hex3));

  typedef struct {
    logic [19:0] addr;
    logic [15:0] wdata;
    logic        wub, wlb, rub, rlb;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [7];
  logic [15:0] model [16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle1();
    b1.Mem_CE = 1'b1; b1.Mem_OE = 1'b1; b1.Mem_WE = 1'b1; b1.Mem_UB = 1'b1; b1.Mem_LB = 1'b1;
  endtask

  task automatic idle3();
    b3.Mem_CE = 1'b1; b3.Mem_OE = 1'b1; b3.Mem_WE = 1'b1; b3.Mem_UB = 1'b1; b3.Mem_LB = 1'b1;
  endtask

  // CPU-style 2-cycle write pulse
  task automatic wr1(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
    @(negedge Clk);
    b1.ADDR = a; b1.Data_from_CPU = d;
    b1.Mem_CE = 1'b0; b1.Mem_WE = 1'b0; b1.Mem_OE = 1'b1; b1.Mem_UB = ub; b1.Mem_LB = lb;
    edge_sample();
    chk("wr_busy", {15'h0, b1.Busy}, 16'h0001);
    @(negedge Clk);
    @(negedge Clk);
    idle1();
  endtask

  // 2-cycle OE read at latency 1: valid after first edge, held after second, cleared after release
  task automatic rd1(input logic [19:0] a, input logic ub, input logic lb, input logic [15:0] exp);
    @(negedge Clk);
    b1.ADDR = a; b1.Mem_CE = 1'b0; b1.Mem_OE = 1'b0; b1.Mem_WE = 1'b1; b1.Mem_UB = ub; b1.Mem_LB = lb;
    edge_sample();
    chk("rd_valid1", {15'h0, b1.Data_valid}, 16'h0001);
    chk("rd_data1", b1.Data_to_CPU, exp);
    @(negedge Clk);
    edge_sample();
    chk("rd_data2", b1.Data_to_CPU, exp);
    @(negedge Clk);
    idle1();
    edge_sample();
    chk("rd_valid_end", {15'h0, b1.Data_valid}, 16'h0000);
  endtask

  task automatic wr3(input logic [19:0] a, input logic [15:0] d);
    @(negedge Clk);
    b3.ADDR = a; b3.Data_from_CPU = d;
    b3.Mem_CE = 1'b0; b3.Mem_WE = 1'b0; b3.Mem_OE = 1'b1; b3.Mem_UB = 1'b0; b3.Mem_LB = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    idle3();
  endtask

  task automatic rd3(input logic [19:0] a, input logic [15:0] exp);
    @(negedge Clk);
    b3.ADDR = a; b3.Mem_CE = 1'b0; b3.Mem_OE = 1'b0; b3.Mem_WE = 1'b1; b3.Mem_UB = 1'b0; b3.Mem_LB = 1'b0;
    edge_sample();
    chk("l3_valid_e1", {14'h0, b3.Busy, b3.Data_valid}, 16'h0002);
    edge_sample();
    chk("l3_valid_e2", {15'h0, b3.Data_valid}, 16'h0000);
    edge_sample();
    chk("l3_valid_e3", {15'h0, b3.Data_valid}, 16'h0001);
    chk("l3_data_e3", b3.Data_to_CPU, exp);
    @(negedge Clk);
    idle3();
    edge_sample();
    chk("l3_release", {14'h0, b3.Busy, b3.Data_valid}, 16'h0000);
  endtask

  initial begin
    logic [15:0] e;
    int          k;
    Reset = 1'b1;
    Switches = 16'h8001;
    b1.ADDR = 20'h00000; b1.Data_from_CPU = 16'h0000; idle1();
    b3.ADDR = 20'h00000; b3.Data_from_CPU = 16'h0000; idle3();
    #12;
    chk("rst_data", b1.Data_to_CPU, 16'h0000);
    chk("rst_flags", {14'h0, b1.Busy, b1.Data_valid}, 16'h0000);
    chk("rst_hex", hex1, 16'h0000);
    @(negedge Clk);
    Reset = 1'b0;

    tbl[0] = '{20'h00005, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};
    tbl[1] = '{20'h00003, 16'h5500, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5500};
    tbl[2] = '{20'h00003, 16'hABCD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h55CD};
    tbl[3] = '{20'h00003, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 16'h5500};
    tbl[4] = '{20'h00407, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777};
    tbl[5] = '{20'h00007, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7777};
    tbl[6] = '{20'hFFFFF, 16'h1357, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1357};
    tbl[6].exp = 16'h1357;
    for (int i = 0; i < 7; i++) begin
      wr1(tbl[i].addr, tbl[i].wdata, tbl[i].wub, tbl[i].wlb);
      rd1(tbl[i].addr, tbl[i].rub, tbl[i].rlb, tbl[i].exp);
    end
    tbl[0].wdata = 16'h0000;
    wr1(20'h00009, 16'hC0DE, 1'b0, 1'b0);
    rd1(20'h00009, 1'b0, 1'b1, 16'hC000);

    // Data changed while WE stays low must not be written a second time
    @(negedge Clk);
    b1.ADDR = 20'h00006; b1.Data_from_CPU = 16'h2468;
    b1.Mem_CE = 1'b0; b1.Mem_WE = 1'b0; b1.Mem_UB = 1'b0; b1.Mem_LB = 1'b0;
    @(negedge Clk);
    b1.Data_from_CPU = 16'h9999;
    @(negedge Clk);
    idle1();
    rd1(20'h00006, 1'b0, 1'b0, 16'h2468);

    // WE and OE low together is a write with no read data
    @(negedge Clk);
    b1.ADDR = 20'h0000A; b1.Data_from_CPU = 16'h4242;
    b1.Mem_CE = 1'b0; b1.Mem_WE = 1'b0; b1.Mem_OE = 1'b0; b1.Mem_UB = 1'b0; b1.Mem_LB = 1'b0;
    edge_sample();
    chk("weoe_valid", {14'h0, b1.Busy, b1.Data_valid}, 16'h0002);
    edge_sample();
    chk("weoe_valid2", {15'h0, b1.Data_valid}, 16'h0000);
    @(negedge Clk);
    idle1();
    rd1(20'h0000A, 1'b0, 1'b0, 16'h4242);

    // MMIO address: in the default build it aliases RAM word 0x3FF
    wr1(20'h0FFFF, 16'h00C3, 1'b0, 1'b0);
`ifdef SRAM_RESPONDER_MMIO_EN
    chk("mmio_hex", hex1, 16'h00C3);
    rd1(20'h0FFFF, 1'b0, 1'b0, 16'h8001);
    rd1(20'h003FF, 1'b0, 1'b0, 16'h1357);
`else
    chk("mmio_hex", hex1, 16'h0000);
    rd1(20'h0FFFF, 1'b0, 1'b0, 16'h00C3);
    rd1(20'h003FF, 1'b0, 1'b0, 16'h00C3);
`endif

    // Randomized traffic over words 0x20..0x2F with random upper address bits
    for (int i = 0; i < 16; i++) begin
      model[i] = 16'($urandom);
      wr1(20'h00020 + 20'(i), model[i], 1'b0, 1'b0);
    end
    for (int i = 0; i < 50; i++) begin
      logic ub, lb;
      logic [19:0] a;
      logic [15:0] d;
      k  = int'($urandom_range(0, 15));
      a  = {10'($urandom_range(0, 1023)), 10'(32 + k)};
      ub = 1'($urandom_range(0, 1));
      lb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        d = 16'($urandom);
        wr1(a, d, ub, lb);
        if (!ub) model[k][15:8] = d[15:8];
        if (!lb) model[k][7:0]  = d[7:0];
      end else begin
        e = model[k];
        if (ub) e[15:8] = 8'h00;
        if (lb) e[7:0]  = 8'h00;
        rd1(a, ub, lb, e);
      end
    end

    // Latency-3 instance: timing, abort, then reset in READ_WAIT
    wr3(20'h00010, 16'h0F0F);
    wr3(20'h00005, 16'h1234);
    rd3(20'h00010, 16'h0F0F);
    @(negedge Clk);
    b3.ADDR = 20'h00005; b3.Mem_CE = 1'b0; b3.Mem_OE = 1'b0; b3.Mem_WE = 1'b1; b3.Mem_UB = 1'b0; b3.Mem_LB = 1'b0;
    edge_sample();
    edge_sample();
    chk("abort_e2", {15'h0, b3.Data_valid}, 16'h0000);
    @(negedge Clk);
    idle3();
    edge_sample();
    chk("abort_flags", {14'h0, b3.Busy, b3.Data_valid}, 16'h0000);
    chk("abort_data", b3.Data_to_CPU, 16'h0F0F);
    edge_sample();
    chk("abort_nopulse", {15'h0, b3.Data_valid}, 16'h0000);
    chk("hex3_zero", hex3, 16'h0000);

    @(negedge Clk);
    b3.ADDR = 20'h00005; b3.Mem_CE = 1'b0; b3.Mem_OE = 1'b0; b3.Mem_WE = 1'b1; b3.Mem_UB = 1'b0; b3.Mem_LB = 1'b0;
    edge_sample();
    chk("rst_mid_busy", {15'h0, b3.Busy}, 16'h0001);
    #1;
    Reset = 1'b1;
    #1;
    chk("rst_mid_data", b3.Data_to_CPU, 16'h0000);
    chk("rst_mid_flags", {14'h0, b3.Busy, b3.Data_valid}, 16'h0000);
    chk("rst_mid_data1", b1.Data_to_CPU, 16'h0000);
    @(negedge Clk);
    idle3();
    Reset = 1'b0;
    rd3(20'h00005, 16'h1234);
    rd1(20'h00005, 1'b0, 1'b0, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the LC-3 datapath's active-low SRAM control bus: Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB.
- Holds a synchronous word-addressed RAM, returns read data with a parameterised latency, and commits writes with byte-lane masking.
- Sits between the CPU's MAR/MDR path and on-chip memory.
- Replaces the external SRAM in simulation and on FPGA builds without the SRAM chip.

Parameters:
ADDR_WIDTH, 10, number of word-address bits actually decoded; depth = 2**ADDR_WIDTH words of 16 bits
READ_LATENCY, 1, rising edges from first OE-low sample to data registered on Data_to_CPU; legal range 1..4

Ports:
Clk  in  1  clock
Reset  in  1  asynchronous, active-high reset
ADDR  in  20  word address from MAR
Data_from_CPU  in  16  write data from MDR
Mem_CE  in  1  chip enable, active low
Mem_OE  in  1  output enable, active low
Mem_WE  in  1  write enable, active low
Mem_UB  in  1  upper byte lane [15:8] enable, active low
Mem_LB  in  1  lower byte lane [7:0] enable, active low
Data_to_CPU  out  16  registered read data
Data_valid  out  1  high while Data_to_CPU holds data for the current read
Busy  out  1  high whenever state != IDLE
Switches  in  16  MMIO input (used only with the optional feature)
Hex_out  out  16  MMIO output register (used only with the optional feature)

Behaviour:
- Reset: Reset, asynchronous, active-high; clock Clk.
  - On reset, state=IDLE, Data_to_CPU=0, Data_valid=0, Busy=0, Hex_out=0, latency counter=0.
  - RAM contents are not cleared.
- Address decode: word index = ADDR[ADDR_WIDTH-1:0]; upper bits ignored, so addresses wrap modulo depth.
- Request sampling: all strobes are sampled at the rising edge of Clk. Request types:
  - Write = CE low & WE low.
  - Read = CE low & OE low & WE high.
  - WE low and OE low together is treated as a write; reads are suppressed.
- State IDLE:
  - On write: commit the enabled bytes of Data_from_CPU to RAM at this edge, then go to WRITE.
  - On read: capture the address and load cnt = READ_LATENCY-1.
    - If cnt=0, register Data_to_CPU at this same edge, set Data_valid=1, go to READ_HOLD.
    - Otherwise go to READ_WAIT.
  - Otherwise stay in IDLE.
- State READ_WAIT:
  - Decrement cnt each edge. When cnt reaches 0, register the data, set Data_valid=1, go to READ_HOLD.
  - CE high or OE high at any edge aborts: go to IDLE, Data_valid=0, Data_to_CPU unchanged.
- State READ_HOLD:
  - Data_to_CPU is re-registered every edge from the captured address; address changes are ignored.
  - Leave to IDLE when CE high or OE high; Data_valid clears at that edge.
- State WRITE:
  - Holds while CE & WE stay low. No further RAM writes occur, so the CPU's 2-cycle WE pulse gives exactly one commit.
  - Return to IDLE when WE high or CE high.
  - A new write needs at least one idle cycle.
- Byte lanes:
  - Write: UB low updates [15:8], LB low updates [7:0]. With both high, nothing is written but the FSM still enters WRITE.
  - Read: a disabled lane returns 8'h00.
- Timing with READ_LATENCY=1: OE is low for two cycles, data is valid in the second cycle, and MDR latches at the end of it.
- Reset mid-read: the read is aborted with no data. Reset mid-write: a write already committed at the entry edge stays.

Optional Feature:
- Macro SRAM_RESPONDER_MMIO_EN.
- When defined, ADDR == 20'hFFFF is decoded as MMIO and bypasses RAM:
  - A read returns Switches, sampled at the data-register edge and subject to the same latency and lane masking.
  - A write loads the enabled bytes of Hex_out.
- When undefined, 20'hFFFF is an ordinary RAM address (wrapped), Hex_out is tied to 0, and Switches is unused.

Test Plan:
- Reset, then write 16'h1234 to 0x0005 (CE/WE/UB/LB low for 2 cycles), then read 0x0005 with OE low for 2 cycles -> Data_to_CPU=16'h1234 and Data_valid=1 in the 2nd OE cycle; RAM written exactly once.
- Write 16'hABCD to 0x0003 with UB high, LB low over an existing 16'h5500 -> read returns 16'h55CD; read with LB high -> 16'h5500.
- READ_LATENCY=3, read 0x0010 holding 16'h0F0F -> Data_valid rises at the 3rd edge after first OE-low sample; raising OE after 2 edges -> no Data_valid pulse, state IDLE.
- ADDR=20'h00407 with ADDR_WIDTH=10 -> accesses word 0x007; WE and OE low together -> write occurs, Data_valid stays 0.
- Assert Reset during READ_WAIT -> Data_to_CPU=0, Data_valid=0, Busy=0 immediately; data previously written at 0x0005 is still readable.
- With SRAM_RESPONDER_MMIO_EN: write 16'h00C3 to 20'hFFFF -> Hex_out=16'h00C3; Switches=16'h8001, read 20'hFFFF -> Data_to_CPU=16'h8001.
